window_dot: RTL and testbench
=============================

WINDOW_DOT -- requirements
Module: window_dot

Interface
REQ-001 Parameters: none; lane count 4 and lane width 8 fixed by pkg_N and pkg_NUM_BITS.
REQ-002 clk_i  input  1  single clock; all state on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 window_i  input  32  4-lane sample window; lane k = window_i[(3-k)*8 +: 8], lane 0 (bits 31:24) = newest.
REQ-005 valid_i  input  1  window_i valid.
REQ-006 ready_o  output  1  block can accept a window this cycle.
REQ-007 coef_i  input  32  4 unsigned 8-bit coefficients, same lane layout as window_i.
REQ-008 coef_load_i  input  1  load coef_i into coefficient register.
REQ-009 result_o  output  18  unsigned dot product, sum over k of lane_k * coef_k.
REQ-010 valid_o  output  1  result_o valid.
REQ-011 ready_i  input  1  downstream accepts result_o.
REQ-012 busy_o  output  1  high in BUSY or DONE.

Function
REQ-013 FSM states IDLE, BUSY, DONE; 2-bit lane counter cnt; 18-bit accumulator acc; captured window register; coefficient register.
REQ-014 ready_o = 1 in IDLE; = ready_i in DONE; = 0 in BUSY.
REQ-015 Accept (valid_i & ready_o): capture window_i, clear acc, cnt = 0, go BUSY.
REQ-016 BUSY: one MAC per cycle, acc += win[cnt] * coef[cnt]; 8x8 unsigned product zero-extended to 18 bits; cnt increments.
REQ-017 BUSY with cnt = 3: final MAC, load result_o with final sum, set valid_o, go DONE.
REQ-018 Latency: valid_o rises on the 4th rising edge after the accepting edge.
REQ-019 DONE: result_o and valid_o held stable while ready_i = 0.
REQ-020 DONE with ready_i = 1 and no accept: clear valid_o, go IDLE.
REQ-021 DONE with ready_i = 1 and valid_i = 1: result retired and new window accepted on the same edge, go BUSY; valid_o low the next cycle.
REQ-022 coef_load_i honoured only when busy_o = 0; ignored in BUSY and DONE.
REQ-023 coef_load_i together with an accept in IDLE: the new coef_i is used for that window.
REQ-024 valid_i while ready_o = 0: no effect; upstream holds window_i.
REQ-025 Accumulator never overflows: maximum sum 4*255*255 = 260100 < 2^18.
REQ-026 result_o keeps its last value after retirement until the next completion.

Reset
REQ-027 rst_i = 1, asynchronously and at any state including mid-BUSY: state IDLE, cnt 0, acc 0, window register 0, coefficient register 0, result_o 0, valid_o 0.
REQ-028 Outputs during and after reset: ready_o = 1, busy_o = 0.
REQ-029 First accept is possible on the first rising edge after rst_i deasserts.

Configuration
REQ-030 Macro WINDOW_DOT_SAT_EN defined: on the final MAC, result_o = min(sum, 18'h0FFFF), i.e. saturated to 65535; acc itself is unsaturated.
REQ-031 Macro WINDOW_DOT_SAT_EN undefined: result_o = full 18-bit sum; no saturation logic present.

Verification
REQ-032 coef 0x01010101 loaded, window 0x01020304 accepted -> valid_o 4 cycles later, result_o = 10.
REQ-033 coef 0xFFFFFFFF, window 0xFFFFFFFF -> result_o = 260100 (0x3F804) without macro; 65535 (0x0FFFF) with WINDOW_DOT_SAT_EN.
REQ-034 ready_i low 3 cycles in DONE -> result_o and valid_o stable; ready_i high with valid_i high -> next window accepted that edge, next result 4 cycles later.
REQ-035 coef_load_i pulsed with 0x02020202 during BUSY -> current and next results use the old coefficients.
REQ-036 rst_i asserted 2 cycles after an accept -> valid_o 0, result_o 0, ready_o 1 immediately, and no result is produced for the aborted window.

Source files
------------

// File: rtl/window_dot_if.sv
// ---------------------------------------------------------------------------
// window_dot_if
//
// Purpose : Groups the sample/coefficient/result handshake signals of
//           window_dot into one bundle. The block itself is the slave. The
//           upstream/downstream environment (or a testbench) is the master.
//
// Signals :
//   window_i    [31:0]  4-lane sample window. Lane 0 (bits 31:24) is the newest.
//   valid_i             window_i valid.
//   ready_o             block can accept a window this cycle.
//   coef_i      [31:0]  4 unsigned 8-bit coefficients, same lane layout.
//   coef_load_i         load coef_i into the coefficient register.
//   result_o    [17:0]  unsigned dot product.
//   valid_o             result_o valid.
//   ready_i             downstream accepts result_o.
//   busy_o              block is computing or holding a result.
// ---------------------------------------------------------------------------
interface window_dot_if;
    logic [31:0] window_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] coef_i;
    logic        coef_load_i;
    logic [17:0] result_o;
    logic        valid_o;
    logic        ready_i;
    logic        busy_o;

    // Environment side: drives samples, coefficients and downstream ready.
    modport master (
        output window_i,
        output valid_i,
        output coef_i,
        output coef_load_i,
        output ready_i,
        input  ready_o,
        input  result_o,
        input  valid_o,
        input  busy_o
    );

    // Block side.
    modport slave (
        input  window_i,
        input  valid_i,
        input  coef_i,
        input  coef_load_i,
        input  ready_i,
        output ready_o,
        output result_o,
        output valid_o,
        output busy_o
    );
endinterface

// File: rtl/window_dot.sv
// ---------------------------------------------------------------------------
// window_dot
//
// Purpose : Serial 4-lane dot product of an 8-bit sample window against a
//           register of four 8-bit unsigned coefficients. One multiply-
//           accumulate is done per clock. The result appears on the 4th
//           rising edge after the window is accepted. It is held until the
//           downstream side takes it.
//
// Ports   :
//   clk_i   single clock. All state changes on the rising edge.
//   rst_i   asynchronous, active-high reset.
//   bus     window_dot_if.slave. This carries window/valid/ready in,
//           coef/coef_load, and result/valid/ready out, plus busy.
//
// Configuration:
//   WINDOW_DOT_SAT_EN  When this macro is defined, the published result is
//                      clamped to 16'hFFFF (65535). The internal accumulator
//                      stays full width.
//                      When it is undefined, the full 18-bit sum is published.
// ---------------------------------------------------------------------------
module window_dot (
    input  logic         clk_i,
    input  logic         rst_i,
    window_dot_if.slave  bus
);

    localparam int pkg_N        = 4;
    localparam int pkg_NUM_BITS = 8;
    localparam int ACC_W        = 18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                            state_reg;
    state_t                            state_next;
    logic [1:0]                        cnt_reg;
    logic [ACC_W-1:0]                  acc_reg;
    logic [pkg_N*pkg_NUM_BITS-1:0]     win_reg;
    logic [pkg_N*pkg_NUM_BITS-1:0]     coef_reg;
    logic [ACC_W-1:0]                  result_reg;
    logic                              valid_reg;

    logic                              ready;
    logic                              busy;
    logic                              accept;
    logic                              last_mac;

    logic [pkg_NUM_BITS-1:0]           win_lane  [pkg_N];
    logic [pkg_NUM_BITS-1:0]           coef_lane [pkg_N];
    logic [2*pkg_NUM_BITS-1:0]         product;
    logic [ACC_W-1:0]                  sum;
    logic [ACC_W-1:0]                  final_value;

    // Split the captured window and coefficient words into lanes.
    // Lane k lives at bits [(3-k)*8 +: 8], so lane 0 is the top byte.
    generate
        for (genvar gi = 0; gi < pkg_N; gi++) begin : g_lane
            assign win_lane[gi]  = win_reg[(pkg_N-1-gi)*pkg_NUM_BITS +: pkg_NUM_BITS];
            assign coef_lane[gi] = coef_reg[(pkg_N-1-gi)*pkg_NUM_BITS +: pkg_NUM_BITS];
        end
    endgenerate

    // One 8x8 unsigned multiply, shared across lanes and selected by the
    // lane counter. The worst-case total of 4*255*255 fits in 18 bits, so
    // the running sum can never wrap.
    assign product  = win_lane[cnt_reg] * coef_lane[cnt_reg];
    assign sum      = acc_reg + {{(ACC_W-2*pkg_NUM_BITS){1'b0}}, product};
    assign last_mac = (state_reg == BUSY) && (cnt_reg == 2'd3);

`ifdef WINDOW_DOT_SAT_EN
    // Clamp only the published value. acc_reg keeps the true sum.
    assign final_value = (sum > 18'h0FFFF) ? 18'h0FFFF : sum;
`else
    assign final_value = sum;
`endif

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt_reg == 2'd3) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Retiring a result and accepting the next window can
                // happen on the same edge. That keeps throughput up with
                // a streaming source.
                if (bus.ready_i) begin
                    state_next = accept ? BUSY : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: output logic
    // ---------------------------------------------------------------
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        case (state_reg)
            IDLE: begin
                ready = 1'b1;
            end
            BUSY: begin
                busy = 1'b1;
            end
            DONE: begin
                // A new window is only taken once the held result is
                // being consumed.
                ready = bus.ready_i;
                busy  = 1'b1;
            end
            default: begin
                ready = 1'b0;
                busy  = 1'b0;
            end
        endcase
    end

    assign accept = bus.valid_i & ready;

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_reg <= 2'd0;
            acc_reg <= '0;
            win_reg <= '0;
        end else if (accept) begin
            win_reg <= bus.window_i;
            acc_reg <= '0;
            cnt_reg <= 2'd0;
        end else if (state_reg == BUSY) begin
            acc_reg <= sum;
            cnt_reg <= cnt_reg + 2'd1;
        end
    end

    // Coefficients can only change while no window is in flight. A load
    // that coincides with an accept in IDLE is therefore seen by that
    // window's first MAC.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            coef_reg <= '0;
        end else if (bus.coef_load_i && !busy) begin
            coef_reg <= bus.coef_i;
        end
    end

    // result_reg is written only on completion, so it keeps the last value
    // after the result has been retired.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_reg <= '0;
            valid_reg  <= 1'b0;
        end else if (last_mac) begin
            result_reg <= final_value;
            valid_reg  <= 1'b1;
        end else if ((state_reg == DONE) && bus.ready_i) begin
            valid_reg  <= 1'b0;
        end
    end

    assign bus.ready_o  = ready;
    assign bus.busy_o   = busy;
    assign bus.result_o = result_reg;
    assign bus.valid_o  = valid_reg;

endmodule

// File: tb/tb_window_dot.sv
// ---------------------------------------------------------------------------
// tb_window_dot
//
// Directed self-checking bench for window_dot. Every expected value below is
// hand-computed from the lane layout (lane 0 = top byte). Each window
// transaction prints one line.
// ---------------------------------------------------------------------------
module tb_window_dot;

`ifdef WINDOW_DOT_SAT_EN
    localparam logic [17:0] EXP_MAX = 18'h0FFFF;
`else
    localparam logic [17:0] EXP_MAX = 18'h3F804;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    window_dot_if bus();

    window_dot dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Present a window for one edge. The caller is at a negedge.
    task automatic send(input logic [31:0] w, input logic [31:0] c, input logic ld);
        bus.window_i    = w;
        bus.coef_i      = c;
        bus.coef_load_i = ld;
        bus.valid_i     = 1'b1;
        #1;
        check("accept_ready", 32'(bus.ready_o), 32'd1);
        @(negedge clk);
        bus.valid_i     = 1'b0;
        bus.coef_load_i = 1'b0;
    endtask

    // Count edges since the accepting edge until valid_o is seen. The count is bounded.
    task automatic wait_result(input string tag, input int start, input logic [17:0] exp);
        int n;
        n = start;
        while (!bus.valid_o && n < 12) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd4);
        check({tag, "_result"}, 32'(bus.result_o), 32'(exp));
        $display("txn %s result=%0d latency=%0d", tag, bus.result_o, n);
    endtask

    initial begin
        int seen;
        bus.window_i    = '0;
        bus.valid_i     = 1'b0;
        bus.coef_i      = '0;
        bus.coef_load_i = 1'b0;
        bus.ready_i     = 1'b0;

        // Reset state
        #1;
        check("rst_ready",  32'(bus.ready_o),  32'd1);
        check("rst_busy",   32'(bus.busy_o),   32'd0);
        check("rst_valid",  32'(bus.valid_o),  32'd0);
        check("rst_result", 32'(bus.result_o), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic: coef load together with first accept, 1+2+3+4 = 10
        send(32'h01020304, 32'h01010101, 1'b1);
        check("a_busy",  32'(bus.busy_o),  32'd1);
        check("a_ready", 32'(bus.ready_o), 32'd0);
        wait_result("a", 0, 18'd10);

        // Hold in DONE while downstream stalls
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_valid",  32'(bus.valid_o),  32'd1);
            check("hold_result", 32'(bus.result_o), 32'd10);
            check("hold_ready",  32'(bus.ready_o),  32'd0);
        end

        // Retire and accept on the same edge: 5+6+7+8 = 26
        bus.ready_i = 1'b1;
        send(32'h05060708, 32'h0, 1'b0);
        check("b2b_valid_low", 32'(bus.valid_o),  32'd0);
        check("b2b_busy",      32'(bus.busy_o),   32'd1);
        check("b2b_old_result",32'(bus.result_o), 32'd10);
        wait_result("b", 0, 18'd26);
        @(negedge clk);
        check("retire_valid",  32'(bus.valid_o),  32'd0);
        check("retire_busy",   32'(bus.busy_o),   32'd0);
        check("retire_result", 32'(bus.result_o), 32'd26);

        // Lane alignment: 0x0A*1 + 0x0D*2 = 36
        send(32'h0A00000D, 32'h01000002, 1'b1);
        wait_result("lanes", 0, 18'd36);
        @(negedge clk);

        // Maximum sum, with a spurious valid_i while BUSY that must be ignored
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        bus.window_i = 32'h0;
        bus.valid_i  = 1'b1;
        @(negedge clk);
        bus.valid_i  = 1'b0;
        wait_result("max", 1, EXP_MAX);
        @(negedge clk);

        // Coefficient load during BUSY is ignored: 4*3 = 12 twice
        send(32'h01010101, 32'h03030303, 1'b1);
        bus.coef_i      = 32'h02020202;
        bus.coef_load_i = 1'b1;
        @(negedge clk);
        bus.coef_load_i = 1'b0;
        wait_result("coef_busy", 1, 18'd12);
        @(negedge clk);
        send(32'h01010101, 32'h0, 1'b0);
        wait_result("coef_keep", 0, 18'd12);
        @(negedge clk);

        // Reset two cycles after an accept aborts the window
        send(32'h01010101, 32'h04040404, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_valid",  32'(bus.valid_o),  32'd0);
        check("abort_result", 32'(bus.result_o), 32'd0);
        check("abort_ready",  32'(bus.ready_o),  32'd1);
        check("abort_busy",   32'(bus.busy_o),   32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.valid_o) seen++;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        $display("txn abort valid_seen=%0d", seen);

        // Coefficients were cleared by reset, so the product is 0
        send(32'h01010101, 32'h0, 1'b0);
        wait_result("coef_cleared", 0, 18'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
